// File: rtl/serial_addsub_unit.sv
// ---------------------------------------------------------------------------
// serial_addsub_unit
//
// Bit-serial adder/subtractor. Two WIDTH-bit operands are loaded in parallel
// on start. They are then combined LSB first, one bit per clock, through a
// single full-adder cell with a carry flip-flop. For subtraction, B is
// inverted at load time and the carry is preset to 1 (A + ~B + 1).
// The result and flags are held in output registers that only change on
// the completion edge or on reset.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   launch an operation (ignored while busy)
//   sub        in   0 = A+B, 1 = A-B (captured on start)
//   data_a     in   operand A (captured on start)
//   data_b     in   operand B (captured on start)
//   busy       out  high while bits are being processed
//   done       out  one-cycle pulse when result/flags become valid
//   out_sum    out  held result register
//   carry_out  out  final carry (subtract: 1 = no borrow)
//   overflow   out  signed two's-complement overflow
// ---------------------------------------------------------------------------
module serial_addsub_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_carry_out;
  logic             r_overflow;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;

  // Full-adder cell on the current LSBs plus the carry flip-flop.
  assign w_s        = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c        = maj3(r_a[0], r_b[0], r_carry);
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SHIFT;
        else       w_next = S_IDLE;
      end
      S_SHIFT: begin
        if (w_last) w_next = S_DONE;
        else        w_next = S_SHIFT;
      end
      S_DONE: begin
        // start in the done cycle chains the next operation with no gap
        if (start) w_next = S_SHIFT;
        else       w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_SHIFT);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Operand load, serial datapath and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_sum       <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_cnt       <= {CNT_W{1'b0}};
      r_out_sum   <= {WIDTH{1'b0}};
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= data_a;
            r_b     <= sub ? ~data_b : data_b;
            r_sum   <= {WIDTH{1'b0}};
            r_carry <= sub;
            r_cnt   <= {CNT_W{1'b0}};
          end
        end
        S_SHIFT: begin
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_sum   <= w_sum_next;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // r_carry here is the carry into the MSB; signed overflow is
            // the disagreement between carry-in and carry-out of the MSB.
            r_out_sum   <= w_sum_next;
            r_carry_out <= w_c;
            r_overflow  <= r_carry ^ w_c;
          end
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_sum   = r_out_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub_unit
//
// Self-checking bench for serial_addsub_unit. A WIDTH=8 instance runs the
// directed and randomized operations; a WIDTH=4 instance covers the narrow
// build. Expected results come from signed/unsigned integer arithmetic.
// ---------------------------------------------------------------------------
module tb_serial_addsub_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       sub;
  logic [7:0] data_a;
  logic [7:0] data_b;
  logic       busy;
  logic       done;
  logic [7:0] out_sum;
  logic       carry_out;
  logic       overflow;

  logic       start4;
  logic       sub4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;
  logic       ovf4;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] prev_sum;
  logic       prev_c;
  logic       prev_v;

  serial_addsub_unit #(.WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub),
    .data_a(data_a), .data_b(data_b), .busy(busy), .done(done),
    .out_sum(out_sum), .carry_out(carry_out), .overflow(overflow)
  );

  serial_addsub_unit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4),
    .data_a(a4), .data_b(b4), .busy(busy4), .done(done4),
    .out_sum(sum4), .carry_out(cout4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, carry_out, sum} from plain integer arithmetic.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int sa;
    int sb;
    int res;
    int ua;
    int ub;
    int ures;
    logic c;
    logic v;
    logic [7:0] r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    res = s ? (sa - sb) : (sa + sb);
    ures = s ? (ua - ub) : (ua + ub);
    v = (res > 127) || (res < -128);
    c = s ? (ua >= ub) : (ures > 255);
    r = ures[7:0];
    model8 = {v, c, r};
  endfunction

  // Present operands with start high for one edge; returns in first busy cycle.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s);
    data_a = a;
    data_b = b;
    sub    = s;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  // Checks the WIDTH busy cycles and the done cycle; returns in the done cycle.
  task automatic body(input logic [7:0] a, input logic [7:0] b, input logic s, input bit poke);
    logic [9:0] e;
    e = model8(a, b, s);
    for (int i = 0; i < 8; i++) begin
      chk("busy_high", busy, 1'b1);
      chk("done_low_while_busy", done, 1'b0);
      chk("sum_held_while_busy", out_sum, prev_sum);
      chk("flags_held_while_busy", {overflow, carry_out}, {prev_v, prev_c});
      data_a = 8'($urandom);
      data_b = 8'($urandom);
      sub    = 1'($urandom);
      if (poke && i == 3) begin
        start  = 1'b1;
        data_a = 8'hFF;
        data_b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("busy_low_at_done", busy, 1'b0);
    chk("out_sum", out_sum, e[7:0]);
    chk("carry_out", carry_out, e[8]);
    chk("overflow", overflow, e[9]);
    prev_sum = e[7:0];
    prev_c   = e[8];
    prev_v   = e[9];
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, input bit poke);
    launch(a, b, s);
    body(a, b, s, poke);
  endtask

  task automatic idle_step();
    step();
    chk("done_single_cycle", done, 1'b0);
    chk("idle_not_busy", busy, 1'b0);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    bit         chain;
    reset  = 1'b1;
    start  = 1'b0;
    sub    = 1'b0;
    data_a = 8'h00;
    data_b = 8'h00;
    start4 = 1'b0;
    sub4   = 1'b0;
    a4     = 4'h0;
    b4     = 4'h0;
    step();
    step();
    reset = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_sum", out_sum, 8'h00);
    chk("reset_flags", {overflow, carry_out}, 2'b00);
    chk("reset4_all", {busy4, done4, sum4, cout4, ovf4}, 8'h00);
    prev_sum = 8'h00;
    prev_c   = 1'b0;
    prev_v   = 1'b0;

    // Directed arithmetic cases
    do_op(8'h35, 8'h4A, 1'b0, 1'b0);
    chk("dir_35_4A", {overflow, carry_out, out_sum}, {2'b00, 8'h7F});
    idle_step();
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    chk("dir_FF_01", {overflow, carry_out, out_sum}, {2'b01, 8'h00});
    idle_step();
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
    chk("dir_7F_01", {overflow, carry_out, out_sum}, {2'b10, 8'h80});
    idle_step();
    do_op(8'h10, 8'h20, 1'b1, 1'b0);
    chk("dir_10_m_20", {overflow, carry_out, out_sum}, {2'b00, 8'hF0});
    idle_step();
    do_op(8'h80, 8'h01, 1'b1, 1'b0);
    chk("dir_80_m_01", {overflow, carry_out, out_sum}, {2'b11, 8'h7F});
    idle_step();

    // Start while busy ignored; then back-to-back launch from the done cycle
    do_op(8'h12, 8'h34, 1'b0, 1'b1);
    chk("ignore_busy_start", out_sum, 8'h46);
    do_op(8'hA5, 8'h3C, 1'b1, 1'b0);
    idle_step();
    step();
    chk("no_spurious_op", {busy, done}, 2'b00);

    // Reset in the middle of an operation
    launch(8'h55, 8'h66, 1'b0);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_sum", out_sum, 8'h00);
    chk("midrst_flags", {overflow, carry_out}, 2'b00);
    prev_sum = 8'h00;
    prev_c   = 1'b0;
    prev_v   = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("midrst_no_done", {busy, done}, 2'b00);
      step();
    end
    do_op(8'h01, 8'h02, 1'b0, 1'b0);
    idle_step();

    // Randomized operations, some chained back-to-back
    chain = 1'b0;
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      do_op(ra, rb, rs, 1'b0);
      chain = 1'($urandom);
      if (!chain) idle_step();
    end
    if (chain) idle_step();

    // Narrow build: 0x9 + 0x8
    a4     = 4'h9;
    b4     = 4'h8;
    sub4   = 1'b0;
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("w4_busy", {busy4, done4}, 2'b10);
      step();
    end
    chk("w4_done", {busy4, done4}, 2'b01);
    chk("w4_sum", sum4, 4'h1);
    chk("w4_flags", {ovf4, cout4}, 2'b11);
    step();
    chk("w4_done_pulse_end", done4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_addsub_unit.md
Name: serial_addsub_unit

Overview:
- Parametrised successor to the team's 4-bit shift-register serial adder.
- Loads two WIDTH-bit operands in parallel, then adds or subtracts them bit-serially, LSB first, one bit per clock, through a single full-adder cell with a carry flip-flop.
- Adds start/busy/done handshaking, a subtract mode, carry-out and signed-overflow flags, and a held result register.
- Sits between the operand source and the result consumer in the serial arithmetic datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..64).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not to be overridden).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only when not busy
- sub  input  1  0 = A+B, 1 = A-B; captured with the operands on start
- data_a  input  WIDTH  operand A, captured on start
- data_b  input  WIDTH  operand B, captured on start
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle pulse; result and flags are valid from this cycle
- out_sum  output  WIDTH  result register, held until the next completion
- carry_out  output  1  final carry; for subtraction 1 = no borrow
- overflow  output  1  signed two's-complement overflow of the operation

Behaviour:
- Reset: reset=1 at a rising edge clears everything to zero: state=IDLE, busy=0, done=0, out_sum=0, carry_out=0, overflow=0, operand shift registers, carry FF and counter. Reset has priority over every other input, including mid-operation; a partial operation is discarded and done is not produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1 at edge k:
  - Load reg_a <= data_a.
  - Load reg_b <= (sub ? ~data_b : data_b).
  - Set carry <= sub, counter <= 0.
  - Go to SHIFT; busy=1 from cycle k+1.
- SHIFT, each cycle:
  - s = reg_a[0]^reg_b[0]^carry.
  - c_next = majority(reg_a[0], reg_b[0], carry).
  - reg_a and reg_b shift right, zero-filled.
  - s shifts into the MSB of the internal sum shift register.
  - carry <= c_next; counter increments.
- Last bit: when counter==WIDTH-1, the carry entering that bit is recorded as c_msb.
- Completion: after WIDTH SHIFT cycles the FSM goes to DONE and, on the same edge:
  - out_sum <= completed sum register.
  - carry_out <= final carry.
  - overflow <= c_msb ^ final carry.
- DONE: done=1, busy=0 for exactly one cycle; then IDLE unless start=1, which launches the next operation with no idle gap.
- Latency: start sampled at edge k; busy high for cycles k+1..k+WIDTH; done high in cycle k+WIDTH+1. Throughput is one operation per WIDTH+1 cycles.
- start while busy=1 is ignored; data_a, data_b and sub may change freely during SHIFT without effect.
- out_sum and the flags never show partial values; they change only on the completion edge or on reset.
- Arithmetic is modulo 2^WIDTH; subtraction is A + ~B + 1.

Test Plan (WIDTH=8 unless noted):
- Add 0x35 + 0x4A, sub=0, start at cycle 0 -> busy cycles 1-8; done cycle 9; out_sum=0x7F, carry_out=0, overflow=0.
- Add 0xFF + 0x01 -> out_sum=0x00, carry_out=1, overflow=0. Then 0x7F + 0x01 -> out_sum=0x80, carry_out=0, overflow=1.
- Subtract 0x10 - 0x20 (sub=1) -> out_sum=0xF0, carry_out=0 (borrow), overflow=0. Subtract 0x80 - 0x01 -> out_sum=0x7F, carry_out=1, overflow=1.
- Start 0x12+0x34, pulse start with 0xFF+0xFF at cycle 4 (busy), change data_a mid-run -> out_sum=0x46 at cycle 9; second request produces no operation; start held high in the DONE cycle launches back-to-back with done again 9 cycles later.
- Reset=1 at cycle 5 of an operation -> next cycle busy=0, done=0, out_sum=0, flags=0; no done pulse follows; a fresh start afterwards completes normally.
- WIDTH=4 build: 0x9 + 0x8 -> done 5 cycles after start; out_sum=0x1, carry_out=1, overflow=1.
